// File: rtl/mfe_host_pkg.sv
`default_nettype none
// ============================================================================
// mfe_host_pkg : shared types and default sizes for the MFE host port
// Rev 1.0      : initial release
// ============================================================================
package mfe_host_pkg;

   localparam int MFE_AW    = 14;
   localparam int MFE_DW    = 8;
   localparam int MFE_DEPTH = 1 << MFE_AW;

   // err_cnt is one bit wider than an address so a full-buffer mismatch count fits
   localparam int MFE_ERR_W = MFE_AW + 1;
   typedef logic [MFE_ERR_W-1:0] err_cnt_t;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARM   = 3'd1,
      S_WAITB = 3'd2,
      S_RUN   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/mfe_host_ram.sv
`default_nettype none
// ============================================================================
// mfe_host_ram : single-clock 1W/1R synchronous RAM, read-before-write
// Rev 1.0      : initial release
// ============================================================================
module mfe_host_ram
   import mfe_host_pkg::*;
#(
   parameter int AW    = MFE_AW,
   parameter int DW    = MFE_DW,
   parameter int DEPTH = MFE_DEPTH
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Only the output register is reset; the array keeps its contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mfe_host_port.sv
`default_nettype none
// ============================================================================
// mfe_host_port : MFE responder - image/result buffers, start handshake, done
// Rev 1.0       : initial release; optional golden compare via MFE_HOST_CMP_EN
// ============================================================================
module mfe_host_port
   import mfe_host_pkg::*;
#(
   parameter int AW      = MFE_AW,
   parameter int DW      = MFE_DW,
   parameter int DEPTH   = MFE_DEPTH,
   parameter int MAX_CYC = 1000000
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          ld_we,
`ifdef MFE_HOST_CMP_EN
   input  logic [AW:0]   ld_addr,
`else
   input  logic [AW-1:0] ld_addr,
`endif
   input  logic [DW-1:0] ld_data,
   input  logic [AW-1:0] rb_addr,
   output logic [DW-1:0] rb_data,
   input  logic          busy,
   output logic          ready,
   input  logic [AW-1:0] iaddr,
   output logic [DW-1:0] idata,
   input  logic [AW-1:0] addr,
   input  logic          wen,
   input  logic [DW-1:0] data_wr,
   output logic [DW-1:0] data_rd,
   output logic          done,
   output logic          tmo,
`ifdef MFE_HOST_CMP_EN
   output logic [AW:0]   err_cnt,
`endif
   output logic          wr_seen
);

   localparam int            CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CW-1:0] CNT_LIM = CW'(MAX_CYC - 1);

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_ready;
   logic          r_done;
   logic          r_tmo;
   logic          r_wr_seen;
   logic          r_idata_vld;

   logic          w_ld_ok;
   logic          w_start_ok;
   logic          w_img_we;
   logic [AW-1:0] w_img_waddr;
   logic [DW-1:0] w_img_q;

   assign w_ld_ok    = (r_state == S_IDLE) || (r_state == S_DONE);
   assign w_start_ok = start && w_ld_ok;

`ifdef MFE_HOST_CMP_EN
   assign w_img_we    = ld_we && w_ld_ok && !ld_addr[AW];
   assign w_img_waddr = ld_addr[AW-1:0];
`else
   assign w_img_we    = ld_we && w_ld_ok;
   assign w_img_waddr = ld_addr;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_ready     <= 1'b0;
         r_done      <= 1'b0;
         r_tmo       <= 1'b0;
         r_wr_seen   <= 1'b0;
         r_idata_vld <= 1'b0;
      end else begin
         r_idata_vld <= 1'b0;
         if (wen && r_state == S_RUN) r_wr_seen <= 1'b1;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state   <= S_ARM;
                  r_done    <= 1'b0;
                  r_tmo     <= 1'b0;
                  r_wr_seen <= 1'b0;
                  r_cnt     <= '0;
               end
            end
            S_ARM: begin
               if (!busy) begin
                  r_ready <= 1'b1;
                  r_state <= S_WAITB;
               end
            end
            S_WAITB: begin
               if (busy) begin
                  r_ready <= 1'b0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               // busy falling takes priority over a timeout on the same edge
               if (!busy) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else if (r_cnt == CNT_LIM) begin
                  r_done  <= 1'b1;
                  r_tmo   <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_cnt       <= r_cnt + CW'(1);
                  r_idata_vld <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   mfe_host_ram #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_img (
      .clk     (clk),
      .rst     (reset),
      .i_we    (w_img_we),
      .i_waddr (w_img_waddr),
      .i_wdata (ld_data),
      .i_re    (1'b1),
      .i_raddr (iaddr),
      .o_rdata (w_img_q)
   );

   // Two result copies with identical writes give MFE and readback their own read port.
   mfe_host_ram #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_res_mfe (
      .clk     (clk),
      .rst     (reset),
      .i_we    (wen),
      .i_waddr (addr),
      .i_wdata (data_wr),
      .i_re    (!wen),
      .i_raddr (addr),
      .o_rdata (data_rd)
   );

   mfe_host_ram #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_res_rb (
      .clk     (clk),
      .rst     (reset),
      .i_we    (wen),
      .i_waddr (addr),
      .i_wdata (data_wr),
      .i_re    (1'b1),
      .i_raddr (rb_addr),
      .o_rdata (rb_data)
   );

`ifdef MFE_HOST_CMP_EN
   logic [DW-1:0] w_gold_q;
   logic [DW-1:0] r_cmp_data;
   logic          r_cmp_vld;
   logic [AW:0]   r_err;
   logic          w_miss;
   logic [AW:0]   w_err_sum;

   mfe_host_ram #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_gold (
      .clk     (clk),
      .rst     (reset),
      .i_we    (ld_we && w_ld_ok && ld_addr[AW]),
      .i_waddr (ld_addr[AW-1:0]),
      .i_wdata (ld_data),
      .i_re    (1'b1),
      .i_raddr (addr),
      .o_rdata (w_gold_q)
   );

   // The golden word arrives a cycle after the write, so the pending compare
   // is folded into err_cnt combinationally to keep it valid alongside done.
   assign w_miss    = r_cmp_vld && (r_cmp_data != w_gold_q);
   assign w_err_sum = (&r_err) ? r_err : r_err + {{AW{1'b0}}, w_miss};
   assign err_cnt   = w_err_sum;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cmp_vld  <= 1'b0;
         r_cmp_data <= '0;
         r_err      <= '0;
      end else begin
         r_cmp_vld  <= wen && (r_state == S_RUN);
         r_cmp_data <= data_wr;
         r_err      <= w_start_ok ? '0 : w_err_sum;
      end
   end
`else
   logic w_unused;
   assign w_unused = w_start_ok;
`endif

   assign ready   = r_ready;
   assign idata   = r_idata_vld ? w_img_q : '0;
   assign done    = r_done;
   assign tmo     = r_tmo;
   assign wr_seen = r_wr_seen;

endmodule
`default_nettype wire

// File: tb/tb_mfe_host_port.sv
`default_nettype none
// ============================================================================
// tb_mfe_host_port : self-checking bench for mfe_host_port (MFE_HOST_CMP_EN aware)
// Rev 1.0          : initial release
// ============================================================================
module tb_mfe_host_port;

   localparam int AW   = 14;
   localparam int DW   = 8;
   localparam int MAXC = 120;
`ifdef MFE_HOST_CMP_EN
   localparam int LAW = AW + 1;
   logic [AW:0] err_cnt;
`else
   localparam int LAW = AW;
`endif

   logic          clk, reset, start, ld_we, busy, wen, ready, done, tmo, wr_seen;
   logic [LAW-1:0] ld_addr;
   logic [DW-1:0] ld_data, rb_data, idata, data_wr, data_rd;
   logic [AW-1:0] rb_addr, iaddr, addr;

   int n_chk  = 0;
   int n_fail = 0;

   logic [DW-1:0] img_m [int];
   logic [DW-1:0] res_m [int];
   logic [DW-1:0] exp_q [$];

   mfe_host_port #(.AW(AW), .DW(DW), .DEPTH(1 << AW), .MAX_CYC(MAXC)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .ld_we   (ld_we),
      .ld_addr (ld_addr),
      .ld_data (ld_data),
      .rb_addr (rb_addr),
      .rb_data (rb_data),
      .busy    (busy),
      .ready   (ready),
      .iaddr   (iaddr),
      .idata   (idata),
      .addr    (addr),
      .wen     (wen),
      .data_wr (data_wr),
      .data_rd (data_rd),
      .done    (done),
      .tmo     (tmo),
`ifdef MFE_HOST_CMP_EN
      .err_cnt (err_cnt),
`endif
      .wr_seen (wr_seen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_img(input logic [AW-1:0] a, input logic [DW-1:0] d);
      ld_we   = 1'b1;
`ifdef MFE_HOST_CMP_EN
      ld_addr = {1'b0, a};
`else
      ld_addr = a;
`endif
      ld_data = d;
      tick();
      ld_we   = 1'b0;
      img_m[int'(a)] = d;
   endtask

   task automatic go_run();
      busy  = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      busy  = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      tick();
      n_chk++;
      if ({ready, done, tmo, wr_seen} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 0000", {ready, done, tmo, wr_seen});
      end
      n_chk++;
      if ({idata, data_rd, rb_data} !== 24'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h expected 000000", {idata, data_rd, rb_data});
      end
      tick();
      reset = 1'b0;
   endtask

   task automatic test_handshake();
      for (int i = 0; i < 4; i++) load_img(AW'(i), DW'(8'h10 + i));
      load_img(AW'(16383), 8'h5C);
      start = 1'b1;
      tick();
      start = 1'b0;
      n_chk++;
      if (ready !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_arm: got %b expected 0", ready);
      end
      tick();
      n_chk++;
      if (ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_rise: got %b expected 1", ready);
      end
      tick();
      tick();
      n_chk++;
      if (ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_hold: got %b expected 1", ready);
      end
      busy = 1'b1;
      tick();
      n_chk++;
      if ({ready, done, wr_seen} !== 3'b000) begin
         n_fail++;
         $display("FAIL ready_fall: got %b expected 000", {ready, done, wr_seen});
      end
   endtask

   task automatic test_image_serve();
      logic [AW-1:0] al [5];
      logic [DW-1:0] e;
      al = '{AW'(2), AW'(16383), AW'(0), AW'(3), AW'(1)};
      for (int i = 0; i < 5; i++) begin
         iaddr = al[i];
         exp_q.push_back(img_m[int'(al[i])]);
         tick();
         e = exp_q.pop_front();
         n_chk++;
         if (idata !== e) begin
            n_fail++;
            $display("FAIL idata_serve[%0d]: got %h expected %h", al[i], idata, e);
         end
      end
      ld_we   = 1'b1;
      ld_addr = LAW'(2);
      ld_data = 8'hEE;
      tick();
      ld_we = 1'b0;
      iaddr = AW'(2);
      tick();
      n_chk++;
      if (idata !== 8'h12) begin
         n_fail++;
         $display("FAIL ld_ignored_run: got %h expected 12", idata);
      end
   endtask

   task automatic test_result();
      logic [DW-1:0] e;
      wen = 1'b1; addr = AW'(5); data_wr = 8'h3C;
      tick();
      n_chk++;
      if (wr_seen !== 1'b1) begin
         n_fail++;
         $display("FAIL wr_seen_run: got %b expected 1", wr_seen);
      end
      data_wr = 8'hA7; rb_addr = AW'(5);
      tick();
      n_chk++;
      if (rb_data !== 8'h3C) begin
         n_fail++;
         $display("FAIL rb_read_before_write: got %h expected 3c", rb_data);
      end
      wen = 1'b0;
      tick();
      n_chk++;
      if ({data_rd, rb_data} !== 16'hA7A7) begin
         n_fail++;
         $display("FAIL res_readback: got %h expected a7a7", {data_rd, rb_data});
      end
      res_m[5] = 8'hA7;
      wen = 1'b1; addr = AW'(6); data_wr = 8'h55;
      tick();
      n_chk++;
      if (data_rd !== 8'hA7) begin
         n_fail++;
         $display("FAIL data_rd_hold: got %h expected a7", data_rd);
      end
      res_m[6] = 8'h55;
      for (int i = 0; i < 4; i++) begin
         addr = AW'(20 + i); data_wr = DW'(8'h31 * (i + 1));
         res_m[20 + i] = data_wr;
         tick();
      end
      wen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         addr = AW'(20 + i);
         exp_q.push_back(res_m[20 + i]);
         tick();
         e = exp_q.pop_front();
         n_chk++;
         if (data_rd !== e) begin
            n_fail++;
            $display("FAIL res_b2b[%0d]: got %h expected %h", 20 + i, data_rd, e);
         end
      end
   endtask

   task automatic test_completion();
      busy = 1'b0;
      tick();
      n_chk++;
      if ({done, tmo, idata} !== {2'b10, 8'h00}) begin
         n_fail++;
         $display("FAIL done_busy_low: got %b %b %h expected 1 0 00", done, tmo, idata);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      n_chk++;
      if ({done, wr_seen} !== 2'b00) begin
         n_fail++;
         $display("FAIL start_clear: got %b expected 00", {done, wr_seen});
      end
      tick();
      busy = 1'b1;
      tick();
      repeat (99) tick();
      n_chk++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL done_early_100: got %b expected 0", done);
      end
      busy = 1'b0;
      tick();
      n_chk++;
      if ({done, tmo} !== 2'b10) begin
         n_fail++;
         $display("FAIL done_100: got %b expected 10", {done, tmo});
      end
      go_run();
      repeat (MAXC - 1) tick();
      n_chk++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL done_early_limit: got %b expected 0", done);
      end
      busy = 1'b0;
      tick();
      n_chk++;
      if ({done, tmo} !== 2'b10) begin
         n_fail++;
         $display("FAIL limit_busy_wins: got %b expected 10", {done, tmo});
      end
   endtask

   task automatic test_timeout();
      int n;
      go_run();
      n = 0;
      while (!done && n < 200) begin
         tick();
         n++;
      end
      n_chk++;
      if ({done, tmo} !== 2'b11 || n != MAXC) begin
         n_fail++;
         $display("FAIL timeout: got done/tmo %b after %0d cycles expected 11 after %0d",
                  {done, tmo}, n, MAXC);
      end
      busy = 1'b0;
      tick();
   endtask

   task automatic test_reset_midrun();
      logic [DW-1:0] e;
      go_run();
      iaddr = AW'(1);
      tick();
      n_chk++;
      if (idata !== 8'h11) begin
         n_fail++;
         $display("FAIL idata_pre_reset: got %h expected 11", idata);
      end
      #2 reset = 1'b1;
      #1;
      n_chk++;
      if ({ready, done, idata} !== 10'h0) begin
         n_fail++;
         $display("FAIL reset_midrun: got %b %b %h expected 0 0 00", ready, done, idata);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      busy = 1'b0;
      wen = 1'b1; addr = AW'(7); data_wr = 8'h77;
      tick();
      wen = 1'b0;
      res_m[7] = 8'h77;
      n_chk++;
      if (wr_seen !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_seen_idle: got %b expected 0", wr_seen);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      n_chk++;
      if (ready !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_ready: got %b expected 1", ready);
      end
      busy = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         iaddr = AW'(i);
         exp_q.push_back(img_m[i]);
         tick();
         e = exp_q.pop_front();
         n_chk++;
         if (idata !== e) begin
            n_fail++;
            $display("FAIL img_kept[%0d]: got %h expected %h", i, idata, e);
         end
      end
      for (int i = 5; i <= 7; i++) begin
         addr = AW'(i);
         exp_q.push_back(res_m[i]);
         tick();
         e = exp_q.pop_front();
         n_chk++;
         if (data_rd !== e) begin
            n_fail++;
            $display("FAIL res_kept[%0d]: got %h expected %h", i, data_rd, e);
         end
      end
      busy = 1'b0;
      tick();
      n_chk++;
      if ({done, tmo} !== 2'b10) begin
         n_fail++;
         $display("FAIL restart_done: got %b expected 10", {done, tmo});
      end
   endtask

`ifdef MFE_HOST_CMP_EN
   task automatic test_cmp();
      for (int i = 0; i < 10; i++) begin
         ld_we = 1'b1; ld_addr = {1'b1, AW'(i)}; ld_data = 8'h00;
         tick();
      end
      ld_we = 1'b0;
      go_run();
      for (int i = 0; i < 10; i++) begin
         wen = 1'b1; addr = AW'(i); data_wr = (i < 8) ? 8'h00 : 8'hFF;
         tick();
      end
      wen = 1'b0;
      busy = 1'b0;
      tick();
      n_chk++;
      if (done !== 1'b1 || err_cnt !== (AW+1)'(2)) begin
         n_fail++;
         $display("FAIL err_cnt: got done %b err_cnt %0d expected 1 2", done, err_cnt);
      end
   endtask
`endif

   initial begin
      reset = 1'b1; start = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
      rb_addr = '0; busy = 1'b0; iaddr = '0; addr = '0; wen = 1'b0; data_wr = '0;
      test_reset();
      test_handshake();
      test_image_serve();
      test_result();
      test_completion();
      test_timeout();
      test_reset_midrun();
`ifdef MFE_HOST_CMP_EN
      test_cmp();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mfe_host_port.md
Name: mfe_host_port

Overview:
- Synthesizable host/memory-side end of the MFE (median filter engine) interface: implements the responder that MFE's initiator talks to.
- Owns the input image buffer (serves `iaddr`/`idata`) and the result buffer (services `addr`/`wen`/`data_wr`/`data_rd`).
- Drives the `ready`/`busy` start handshake and reports completion.
- Sits between MFE and the system loader/readback logic, so the filter can run on FPGA without the simulation fixture.

Parameters:
- AW, 14, address width for image and result buffers.
- DW, 8, pixel width.
- DEPTH, 16384, words per buffer (2**AW).
- MAX_CYC, 1000000, RUN-state cycle budget before timeout; minimum 1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to launch a filter run.
- ld_we  in  1  image-buffer load write enable.
- ld_addr  in  AW  image-buffer load address.
- ld_data  in  DW  image-buffer load data.
- rb_addr  in  AW  result-buffer readback address.
- rb_data  out  DW  result readback data.
- busy  in  1  from MFE.
- ready  out  1  to MFE.
- iaddr  in  AW  MFE image read address.
- idata  out  DW  image pixel to MFE.
- addr  in  AW  MFE result-buffer address.
- wen  in  1  MFE result access: 1 = write, 0 = read.
- data_wr  in  DW  MFE write data.
- data_rd  out  DW  result-buffer read data to MFE.
- done  out  1  run finished; level signal.
- tmo  out  1  run ended by timeout; level signal.
- wr_seen  out  1  at least one MFE write in the current run.

Behaviour:
- Reset values: ready=0, idata=0, data_rd=0, rb_data=0, done=0, tmo=0, wr_seen=0, state=IDLE, cycle counter=0. Buffer contents are not reset.
- FSM states: IDLE, ARM, WAITB, RUN, DONE.
- IDLE:
  - start=1 → ARM.
  - Clears done, tmo, wr_seen and the counter on that edge.
- ARM:
  - When busy==0 is sampled, ready=1 on the next edge → WAITB.
- WAITB:
  - ready stays 1 until busy==1 is sampled.
  - On that edge ready=0 → RUN.
  - busy rising in the same cycle ready rises is legal: one-cycle ready pulse.
- RUN:
  - Each edge: idata <= img[iaddr]. One-cycle latency; idata is valid in the cycle after iaddr is presented.
  - Counter increments each cycle.
  - busy==0 sampled → DONE with done=1.
  - Counter reaching MAX_CYC-1 while busy==1 → DONE with done=1, tmo=1.
  - If busy falls in the same cycle the counter hits the limit, the busy path wins and tmo=0.
- Outside RUN, idata=0.
- DONE:
  - done holds until the next start.
  - start → ARM, with the same clear as from IDLE.
- Result port, all states:
  - wen=1: res[addr] <= data_wr at the edge; wr_seen <= 1 if the FSM is in RUN.
  - wen=0: data_rd <= res[addr] at the edge (1-cycle latency).
  - While wen=1, data_rd holds its previous value.
- Loader:
  - ld_we is honoured only in IDLE/DONE; it is ignored in ARM/WAITB/RUN so the image stays stable during a run.
- Readback:
  - rb_data <= res[rb_addr] every edge.
  - Same-cycle MFE write to the same address returns old data (read-before-write).
- Addresses are AW bits wide and wrap naturally; there is no out-of-range check.
- start while in ARM/WAITB/RUN is ignored.
- Reset asserted mid-run: immediate return to IDLE, outputs to reset values. Buffers keep their contents.

Optional Feature:
- Macro: MFE_HOST_CMP_EN.
- Defined:
  - Adds a golden buffer loaded via ld_we with ld_addr[AW] as the select bit (ld_addr widens to AW+1: 0 = image, 1 = golden).
  - Each RUN-state MFE write compares data_wr against gold[addr].
  - Adds output err_cnt (AW+1 bits, saturating, cleared on start), valid when done=1.
- Undefined:
  - No golden buffer, no err_cnt port, ld_addr is AW bits.

Decomposition:
- Package mfe_host_pkg:
  - FSM state enum.
  - Default AW/DW/DEPTH localparams.
  - Width of the err_cnt type.
- One sub-module, mfe_host_ram: single-clock dual-port synchronous RAM (1 write, 1 read, read-before-write).
  - Instantiated for the image buffer and the result buffer (and the golden buffer when MFE_HOST_CMP_EN is defined).
  - The result buffer needs a second read port for readback: use two ram instances with duplicated writes.

Test Plan:
- Handshake: load img[0..3]=0x10..0x13, pulse start, busy model held 0 → ready=1 two edges later. Raise busy → ready=0 next edge, state RUN.
- Image serve: in RUN drive iaddr=2 → idata=0x12 one cycle later. Drive iaddr=16383 → img[16383]. Leave RUN → idata=0.
- Result write/read: wen=1, addr=5, data_wr=0xA7, then wen=0, addr=5 → data_rd=0xA7 next cycle and wr_seen=1. Concurrent rb_addr=5 on the write cycle → old value.
- Completion/timeout: busy falls after 100 cycles → done=1, tmo=0. With MAX_CYC=50 and busy stuck 1 → done=1, tmo=1 exactly 50 RUN cycles after entry.
- Reset mid-run: assert reset during RUN → ready/idata/done=0 immediately. Restart → full handshake works, buffers unchanged.
- With MFE_HOST_CMP_EN: golden[0..9]=0x00, MFE writes 0x00 to 8 addresses and 0xFF to 2 → err_cnt=2 at done.
